// File: rtl/rv32_pkg.sv
// Shared RV32I core types and widths for the register file and its scoreboard.
package rv32_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;
    localparam int IDX_W     = $clog2(REG_COUNT);

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  xlen_t;

    // x0 is hardwired to zero: never written, never busy.
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback <-> register file bundle: read ports, writeback port, issue info.
interface register_file_scoreboard_if import rv32_pkg::*; ();

    reg_idx_t               rs1_read_index;
    xlen_t                  rs1_read_data;
    reg_idx_t               rs2_read_index;
    xlen_t                  rs2_read_data;
    logic                   rd_write_en;
    reg_idx_t               rd_write_index;
    xlen_t                  rd_write_data;
    logic                   issue_valid;
    logic                   issue_rd_en;
    reg_idx_t               issue_rd_index;
    logic                   issue_rs1_used;
    logic                   issue_rs2_used;
    logic                   hazard;
    logic [REG_COUNT-1:0]   busy_vector;

    // Pipeline side: decode and writeback drive requests, observe data and stall.
    modport master (
        output rs1_read_index, rs2_read_index,
        output rd_write_en, rd_write_index, rd_write_data,
        output issue_valid, issue_rd_en, issue_rd_index, issue_rs1_used, issue_rs2_used,
        input  rs1_read_data, rs2_read_data, hazard, busy_vector
    );

    // Register file side.
    modport slave (
        input  rs1_read_index, rs2_read_index,
        input  rd_write_en, rd_write_index, rd_write_data,
        input  issue_valid, issue_rd_en, issue_rd_index, issue_rs1_used, issue_rs2_used,
        output rs1_read_data, rs2_read_data, hazard, busy_vector
    );

endinterface

// File: rtl/register_file_scoreboard_scoreboard.sv
// Per-register busy tracking: set at issue, cleared at writeback, set wins on collision.
module reg_scoreboard import rv32_pkg::*; #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid_i,
    input  logic                 issue_rd_en_i,
    input  reg_idx_t             issue_rd_index_i,
    input  logic                 issue_rs1_used_i,
    input  logic                 issue_rs2_used_i,
    input  reg_idx_t             rs1_index_i,
    input  reg_idx_t             rs2_index_i,
    input  logic                 wb_en_i,
    input  reg_idx_t             wb_index_i,
    output logic                 hazard_o,
    output logic [REG_COUNT-1:0] busy_o
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_COUNT-1:0] set_vec;
    logic [REG_COUNT-1:0] clr_vec;
    logic                 rs1_pend;
    logic                 rs2_pend;

    // A source is pending if its producer has not retired, unless it retires this
    // cycle and the bypass path will deliver the value.
    always_comb begin
        rs1_pend = busy_q[rs1_index_i] & ~(BYPASS_EN & wb_en_i & (wb_index_i == rs1_index_i));
        rs2_pend = busy_q[rs2_index_i] & ~(BYPASS_EN & wb_en_i & (wb_index_i == rs2_index_i));
        hazard_o = issue_valid_i & ((issue_rs1_used_i & rs1_pend) | (issue_rs2_used_i & rs2_pend));
    end

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign set_vec[gi] = 1'b0;
        end else begin : g_reg
            assign set_vec[gi] = issue_valid_i & issue_rd_en_i & ~hazard_o
                               & (issue_rd_index_i == reg_idx_t'(gi));
        end
        assign clr_vec[gi] = wb_en_i & (wb_index_i == reg_idx_t'(gi));
        // New producer supersedes a retiring one on the same register.
        assign busy_d[gi]  = set_vec[gi] ? 1'b1 : (clr_vec[gi] ? 1'b0 : busy_q[gi]);
    end

    // Busy state register; reset drops every outstanding producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// RV32I architectural register file: two async read ports with writeback bypass,
// one sync write port, and a busy scoreboard that stalls decode on RAW hazards.
module register_file_scoreboard import rv32_pkg::*; #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    register_file_scoreboard_if.slave   bus
);

    xlen_t regs_q [REG_COUNT];

    // Returns the architectural value seen by a read port this cycle.
    function automatic xlen_t read_port(input reg_idx_t idx, input xlen_t stored,
                                        input logic we, input reg_idx_t wi, input xlen_t wd);
        xlen_t value;
        if (idx == REG_ZERO) begin
            value = '0;
        end else if (BYPASS_EN && we && (wi == idx)) begin
            value = wd;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Storage array; cleared asynchronously so reads are 0 throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.rd_write_en && (bus.rd_write_index != REG_ZERO)) begin
            regs_q[bus.rd_write_index] <= bus.rd_write_data;
        end
    end

    // Read muxes, each port bypassing independently.
    always_comb begin
        bus.rs1_read_data = read_port(bus.rs1_read_index, regs_q[bus.rs1_read_index],
                                      bus.rd_write_en, bus.rd_write_index, bus.rd_write_data);
        bus.rs2_read_data = read_port(bus.rs2_read_index, regs_q[bus.rs2_read_index],
                                      bus.rd_write_en, bus.rd_write_index, bus.rd_write_data);
    end

    reg_scoreboard #(.BYPASS_EN(BYPASS_EN)) u_scoreboard (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid_i    (bus.issue_valid),
        .issue_rd_en_i    (bus.issue_rd_en),
        .issue_rd_index_i (bus.issue_rd_index),
        .issue_rs1_used_i (bus.issue_rs1_used),
        .issue_rs2_used_i (bus.issue_rs2_used),
        .rs1_index_i      (bus.rs1_read_index),
        .rs2_index_i      (bus.rs2_read_index),
        .wb_en_i          (bus.rd_write_en),
        .wb_index_i       (bus.rd_write_index),
        .hazard_o         (bus.hazard),
        .busy_o           (bus.busy_vector)
    );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench: two register files (bypass on / off) share one stimulus stream
// and are compared against a behavioural model of registers and outstanding producers.
module tb_register_file_scoreboard;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_idx_t rs1_idx, rs2_idx, wi, iss_rd;
    logic     we, iv, ird_en, u1, u2;
    xlen_t    wd;

    register_file_scoreboard_if if_b0 ();
    register_file_scoreboard_if if_b1 ();

    assign if_b0.rs1_read_index = rs1_idx;  assign if_b1.rs1_read_index = rs1_idx;
    assign if_b0.rs2_read_index = rs2_idx;  assign if_b1.rs2_read_index = rs2_idx;
    assign if_b0.rd_write_en    = we;       assign if_b1.rd_write_en    = we;
    assign if_b0.rd_write_index = wi;       assign if_b1.rd_write_index = wi;
    assign if_b0.rd_write_data  = wd;       assign if_b1.rd_write_data  = wd;
    assign if_b0.issue_valid    = iv;       assign if_b1.issue_valid    = iv;
    assign if_b0.issue_rd_en    = ird_en;   assign if_b1.issue_rd_en    = ird_en;
    assign if_b0.issue_rd_index = iss_rd;   assign if_b1.issue_rd_index = iss_rd;
    assign if_b0.issue_rs1_used = u1;       assign if_b1.issue_rs1_used = u1;
    assign if_b0.issue_rs2_used = u2;       assign if_b1.issue_rs2_used = u2;

    register_file_scoreboard #(.BYPASS_EN(1'b0)) dut_b0 (.clk(clk), .rst_n(rst_n), .bus(if_b0.slave));
    register_file_scoreboard #(.BYPASS_EN(1'b1)) dut_b1 (.clk(clk), .rst_n(rst_n), .bus(if_b1.slave));

    // Index 0 = bypass disabled, index 1 = bypass enabled.
    xlen_t       rd1 [2];
    xlen_t       rd2 [2];
    logic        hz  [2];
    logic [31:0] bv  [2];
    assign rd1[0] = if_b0.rs1_read_data;  assign rd1[1] = if_b1.rs1_read_data;
    assign rd2[0] = if_b0.rs2_read_data;  assign rd2[1] = if_b1.rs2_read_data;
    assign hz[0]  = if_b0.hazard;         assign hz[1]  = if_b1.hazard;
    assign bv[0]  = if_b0.busy_vector;    assign bv[1]  = if_b1.busy_vector;

    // Reference model: architectural register values and which registers await a producer.
    xlen_t       regs_m [32];
    logic [31:0] busy_m [2];
    int checks = 0;
    int errors = 0;

    function automatic xlen_t exp_read(input int b, input reg_idx_t idx);
        if (idx == 0) return '0;
        if (b == 1 && we && wi == idx) return wd;
        return regs_m[idx];
    endfunction

    function automatic logic exp_hazard(input int b);
        logic p1, p2;
        p1 = busy_m[b][rs1_idx] && !(b == 1 && we && wi == rs1_idx);
        p2 = busy_m[b][rs2_idx] && !(b == 1 && we && wi == rs2_idx);
        return iv && ((u1 && p1) || (u2 && p2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        busy_m[0] = '0;
        busy_m[1] = '0;
    endtask

    task automatic idle();
        rs1_idx = '0; rs2_idx = '0; wi = '0; iss_rd = '0; wd = '0;
        we = 0; iv = 0; ird_en = 0; u1 = 0; u2 = 0;
    endtask

    // Advance one clock edge and update the model with the inputs that were applied.
    task automatic tick();
        logic h [2];
        @(posedge clk);
        if (rst_n) begin
            for (int b = 0; b < 2; b++) h[b] = exp_hazard(b);
            for (int b = 0; b < 2; b++) begin
                if (we) busy_m[b][wi] = 1'b0;
                if (iv && ird_en && !h[b] && iss_rd != 0) busy_m[b][iss_rd] = 1'b1;
            end
            if (we && wi != 0) regs_m[wi] = wd;
        end
        #1;
    endtask

    task automatic test_reset_x0();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b] !== 32'h0 || hz[b] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state b%0d: busy=%h hazard=%b, expected busy=0 hazard=0", b, bv[b], hz[b]);
            end
        end
        rst_n = 1;
        we = 1; wi = 5'd1; wd = $urandom | 32'h1;
        iv = 1; ird_en = 1; iss_rd = 5'd2;
        tick();
        @(negedge clk);
        idle();
        iv = 1; u1 = 1; u2 = 1;
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            rs1_idx = reg_idx_t'(i);
            rs2_idx = reg_idx_t'(31 - i);
            #1;
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (rd1[b] !== 32'h0 || rd2[b] !== 32'h0 || hz[b] !== 1'b0 || bv[b] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_read b%0d idx%0d: rs1=%h rs2=%h hz=%b busy=%h, expected all 0",
                             b, i, rd1[b], rd2[b], hz[b], bv[b]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1;
        idle();
        we = 1; wi = 5'd0; wd = 32'hDEADBEEF;
        iv = 1; ird_en = 1; iss_rd = 5'd0;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rd1[b] !== 32'h0) begin
                errors++;
                $display("FAIL x0_bypass b%0d: rs1=%h, expected 0", b, rd1[b]);
            end
        end
        tick();
        @(negedge clk);
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rd1[b] !== 32'h0 || bv[b][0] !== 1'b0) begin
                errors++;
                $display("FAIL x0_write b%0d: rs1=%h busy0=%b, expected 0 and 0", b, rd1[b], bv[b][0]);
            end
        end
        $display("test_reset_x0 done");
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle();
        we = 1; wi = 5'd5; wd = 32'h12345678;
        tick();
        @(negedge clk);
        idle();
        rs1_idx = 5'd5; rs2_idx = 5'd6;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rd1[b] !== 32'h12345678 || rd2[b] !== 32'h0) begin
                errors++;
                $display("FAIL write_read b%0d: rs1=%h rs2=%h, expected 12345678 00000000", b, rd1[b], rd2[b]);
            end
        end
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        xlen_t want;
        @(negedge clk);
        idle();
        we = 1; wi = 5'd7; wd = 32'hA5A5A5A5;
        rs1_idx = 5'd7; rs2_idx = 5'd7;
        #1;
        for (int b = 0; b < 2; b++) begin
            want = (b == 1) ? 32'hA5A5A5A5 : 32'h0;
            checks++;
            if (rd1[b] !== want || rd2[b] !== want) begin
                errors++;
                $display("FAIL bypass b%0d: rs1=%h rs2=%h, expected %h", b, rd1[b], rd2[b], want);
            end
        end
        tick();
        @(negedge clk);
        we = 0;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rd1[b] !== 32'hA5A5A5A5 || rd2[b] !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL bypass_after b%0d: rs1=%h rs2=%h, expected a5a5a5a5", b, rd1[b], rd2[b]);
            end
        end
        $display("test_bypass done");
    endtask

    task automatic test_raw_hazard();
        xlen_t v;
        @(negedge clk);
        idle();
        iv = 1; ird_en = 1; iss_rd = 5'd3;
        tick();
        @(negedge clk);
        idle();
        iv = 1; ird_en = 1; iss_rd = 5'd10; rs1_idx = 5'd3; u1 = 1;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b][3] !== 1'b1 || hz[b] !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall b%0d: busy3=%b hz=%b, expected 1 1", b, bv[b][3], hz[b]);
            end
        end
        tick();
        @(negedge clk);
        v = $urandom;
        we = 1; wi = 5'd3; wd = v;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b][10] !== 1'b0 || hz[b] !== (b == 0) || rd1[b] !== ((b == 1) ? v : 32'h0)) begin
                errors++;
                $display("FAIL raw_wb b%0d: busy10=%b hz=%b rs1=%h, expected 0 %0d %h",
                         b, bv[b][10], hz[b], rd1[b], (b == 0), ((b == 1) ? v : 32'h0));
            end
        end
        tick();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b][3] !== 1'b0 || bv[b][10] !== (b == 1) || bv[b] !== busy_m[b]) begin
                errors++;
                $display("FAIL raw_retire b%0d: busy=%h, expected %h", b, bv[b], busy_m[b]);
            end
        end
        $display("test_raw_hazard done");
    endtask

    task automatic test_set_wins();
        xlen_t v;
        @(negedge clk);
        idle();
        iv = 1; ird_en = 1; iss_rd = 5'd4;
        tick();
        @(negedge clk);
        v = $urandom;
        we = 1; wi = 5'd4; wd = v;
        tick();
        @(negedge clk);
        idle();
        rs2_idx = 5'd4;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b][4] !== 1'b1 || rd2[b] !== v) begin
                errors++;
                $display("FAIL set_wins b%0d: busy4=%b rs2=%h, expected 1 %h", b, bv[b][4], rd2[b], v);
            end
        end
        $display("test_set_wins done");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle();
        we = 1; wi = 5'd9; wd = 32'h00000055;
        iv = 1; ird_en = 1; iss_rd = 5'd9;
        tick();
        @(negedge clk);
        idle();
        iv = 1; u1 = 1; rs1_idx = 5'd9;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b][9] !== 1'b1 || hz[b] !== 1'b1 || rd1[b] !== 32'h55) begin
                errors++;
                $display("FAIL pre_reset b%0d: busy9=%b hz=%b rs1=%h, expected 1 1 00000055", b, bv[b][9], hz[b], rd1[b]);
            end
        end
        @(posedge clk);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bv[b] !== 32'h0 || hz[b] !== 1'b0 || rd1[b] !== 32'h0) begin
                errors++;
                $display("FAIL async_reset b%0d: busy=%h hz=%b rs1=%h, expected 0 0 0", b, bv[b], hz[b], rd1[b]);
            end
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rs1_idx = reg_idx_t'($urandom_range(0, 7));
            rs2_idx = reg_idx_t'($urandom_range(0, 7));
            we      = ($urandom_range(0, 2) == 0);
            wi      = reg_idx_t'($urandom_range(0, 7));
            wd      = $urandom;
            iv      = ($urandom_range(0, 3) != 0);
            ird_en  = ($urandom_range(0, 3) != 0);
            iss_rd  = reg_idx_t'($urandom_range(0, 7));
            u1      = $urandom_range(0, 1);
            u2      = $urandom_range(0, 1);
            #1;
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (rd1[b] !== exp_read(b, rs1_idx) || rd2[b] !== exp_read(b, rs2_idx) || hz[b] !== exp_hazard(b)) begin
                    errors++;
                    $display("FAIL rand_comb n%0d b%0d: rs1=%h rs2=%h hz=%b, expected %h %h %b",
                             n, b, rd1[b], rd2[b], hz[b], exp_read(b, rs1_idx), exp_read(b, rs2_idx), exp_hazard(b));
                end
            end
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (bv[b] !== busy_m[b]) begin
                    errors++;
                    $display("FAIL rand_busy n%0d b%0d: busy=%h, expected %h", n, b, bv[b], busy_m[b]);
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        idle();
        model_reset();
        test_reset_x0();
        test_write_read();
        test_bypass();
        test_raw_hazard();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
